// File: rtl/fpu_issue_unit.sv
// -----------------------------------------------------------------------------
// fpu_issue_unit
//
// Issue-side front end of the floating-point pipeline. Abstract FP operations
// arrive over a valid/ready handshake. Each one is encoded as a 32-bit RISC-V
// F-extension word and driven to the FPU on `instruction`, one word per cycle.
// The FPU has no interlocks, so a small destination scoreboard holds back any
// operation that reads a register still in flight. The unit emits all-zero
// bubble words until that read-after-write hazard has cleared.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   op_valid/op_ready   operation handshake (op_ready is combinational)
//   op_code             operation select (see op_e)
//   rd, rs1, rs2, rs3   register fields
//   rm                  rounding mode for arithmetic ops
//   instruction         registered word to the FPU (bubble = 32'h0)
//   issued              high while `instruction` holds a real word
//   reject              one-cycle pulse after an unsupported op is consumed
//   issue_count         saturating count of real words
//   bubble_count        saturating count of bubbles emitted with op_valid high
// -----------------------------------------------------------------------------
module fpu_issue_unit #(
    parameter int HAZARD_DEPTH = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [4:0]       op_code,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rs3,
    input  logic [2:0]       rm,
    output logic [31:0]      instruction,
    output logic             issued,
    output logic             reject,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic [4:0] {
        OP_FNOP     = 5'd0,
        OP_FMADD    = 5'd1,
        OP_FMSUB    = 5'd2,
        OP_FNMSUB   = 5'd3,
        OP_FNMADD   = 5'd4,
        OP_FADD     = 5'd5,
        OP_FSUB     = 5'd6,
        OP_FMUL     = 5'd7,
        OP_FDIV     = 5'd8,
        OP_FSQRT    = 5'd9,
        OP_FSGNJ    = 5'd10,
        OP_FSGNJN   = 5'd11,
        OP_FSGNJX   = 5'd12,
        OP_FMIN     = 5'd13,
        OP_FMAX     = 5'd14,
        OP_FCVRTWS  = 5'd15,
        OP_FCVRTWUS = 5'd16,
        OP_FMVXW    = 5'd17,
        OP_FEQ      = 5'd18,
        OP_FLT      = 5'd19,
        OP_FLE      = 5'd20,
        OP_FCLASS   = 5'd21,
        OP_FCVRTSW  = 5'd22,
        OP_FCVRTSWU = 5'd23,
        OP_FMVWX    = 5'd24
    } op_e;

    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;

    // ---------------------------------------------------------------- decode
    logic        supported;
    logic        uses_rs2;
    logic        uses_rs3;
    logic [6:0]  opcode;
    logic [4:0]  top5;       // funct5 for OP-FP, rs3 for the FMA family
    logic [2:0]  funct3;
    logic [4:0]  rs2_field;
    logic [31:0] enc_word;

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        supported = 1'b1;
        uses_rs2  = 1'b1;
        uses_rs3  = 1'b0;
        opcode    = OPC_OP_FP;
        top5      = 5'b00000;
        funct3    = rm;
        rs2_field = rs2;
        case (op_e'(op_code))
            OP_FMADD:  begin opcode = OPC_FMADD;  top5 = rs3; uses_rs3 = 1'b1; end
            OP_FMSUB:  begin opcode = OPC_FMSUB;  top5 = rs3; uses_rs3 = 1'b1; end
            OP_FNMSUB: begin opcode = OPC_FNMSUB; top5 = rs3; uses_rs3 = 1'b1; end
            OP_FNMADD: begin opcode = OPC_FNMADD; top5 = rs3; uses_rs3 = 1'b1; end
            OP_FADD:   top5 = 5'b00000;
            OP_FSUB:   top5 = 5'b00001;
            OP_FMUL:   top5 = 5'b00010;
            OP_FDIV:   top5 = 5'b00011;
            OP_FSQRT:  begin top5 = 5'b01011; rs2_field = 5'd0; uses_rs2 = 1'b0; end
            OP_FSGNJ:  begin top5 = 5'b00100; funct3 = 3'b000; end
            OP_FSGNJN: begin top5 = 5'b00100; funct3 = 3'b001; end
            OP_FSGNJX: begin top5 = 5'b00100; funct3 = 3'b010; end
            OP_FMIN:   begin top5 = 5'b00101; funct3 = 3'b000; end
            OP_FMAX:   begin top5 = 5'b00101; funct3 = 3'b001; end
            OP_FLE:    begin top5 = 5'b10100; funct3 = 3'b000; end
            OP_FLT:    begin top5 = 5'b10100; funct3 = 3'b001; end
            OP_FEQ:    begin top5 = 5'b10100; funct3 = 3'b010; end
            OP_FCLASS: begin
                top5      = 5'b11100;
                funct3    = 3'b001;
                rs2_field = 5'd0;
                uses_rs2  = 1'b0;
            end
            // FNOP, conversions, moves and codes 25-31 are consumed and rejected.
            default:   supported = 1'b0;
        endcase
        enc_word = {top5, 2'b00, rs2_field, rs1, funct3, rd, opcode};
    end

    // ------------------------------------------------------------ scoreboard
    // Slot 0 is the word currently on `instruction`; slot HAZARD_DEPTH-1 is the
    // oldest still in the FPU pipeline. An entry that shifts out has landed.
    logic [HAZARD_DEPTH-1:0]      sb_valid_q;
    logic [HAZARD_DEPTH-1:0][4:0] sb_rd_q;

    logic raw_hit;
    logic hazard;

    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if (sb_valid_q[i]) begin
                if (rs1 == sb_rd_q[i])              raw_hit = 1'b1;
                if (uses_rs2 && rs2 == sb_rd_q[i])  raw_hit = 1'b1;
                if (uses_rs3 && rs3 == sb_rd_q[i])  raw_hit = 1'b1;
            end
        end
        // Destinations are never compared: a WAW conflict alone does not stall.
        hazard = op_valid && supported && raw_hit;
    end

    assign op_ready = !rst && !hazard;

    // ------------------------------------------------------------ next state
    logic             accept;
    logic             issue_real;
    logic [31:0]      instr_d,  instr_q;
    logic             issued_d, issued_q;
    logic             reject_d, reject_q;
    logic [CNT_W-1:0] issue_cnt_d,  issue_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        accept     = op_valid && op_ready;
        issue_real = accept && supported;
        instr_d    = issue_real ? enc_word : 32'h0000_0000;
        issued_d   = issue_real;
        reject_d   = accept && !supported;

        issue_cnt_d = issue_cnt_q;
        if (issue_real && !(&issue_cnt_q))
            issue_cnt_d = issue_cnt_q + 1'b1;

        // A bubble with op_valid high is either a stall or a reject.
        bubble_cnt_d = bubble_cnt_q;
        if (op_valid && !issue_real && !(&bubble_cnt_q))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments only, so the shift
    // below reads every slot's old value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q      <= 32'h0000_0000;
            issued_q     <= 1'b0;
            reject_q     <= 1'b0;
            issue_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            // NOTE: the scoreboard is reset (unlike a data memory) because stale
            // valid bits from before reset would stall the first operation.
            sb_valid_q   <= '0;
            sb_rd_q      <= '0;
        end else begin
            instr_q      <= instr_d;
            issued_q     <= issued_d;
            reject_q     <= reject_d;
            issue_cnt_q  <= issue_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
                sb_valid_q[i] <= sb_valid_q[i-1];
                sb_rd_q[i]    <= sb_rd_q[i-1];
            end
            sb_valid_q[0] <= issue_real;
            sb_rd_q[0]    <= rd;
        end
    end

    assign instruction  = instr_q;
    assign issued       = issued_q;
    assign reject       = reject_q;
    assign issue_count  = issue_cnt_q;
    assign bubble_count = bubble_cnt_q;

endmodule

// File: doc/fpu_issue_unit.md
# fpu_issue_unit

Issue-side front end of the floating-point pipeline. Accepts abstract FP operations over a valid/ready handshake, encodes each as a 32-bit RISC-V F-extension instruction word, and drives the FPU `instruction` input once per cycle. The FPU has no forwarding or interlock: a result lands in its register file four edges after the word is presented. This block therefore keeps a destination scoreboard and emits all-zero bubble words until a read-after-write hazard has cleared.

## Interface
- `HAZARD_DEPTH`, default 3: number of issued words tracked for RAW hazards; fixed by the FPU's 4-stage pipeline.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `op_valid`  in  1: an operation is presented.
- `op_ready`  out  1: operation accepted this edge when high with `op_valid`.
- `op_code`  in  5: operation select. FNOP=0, FMADD=1, FMSUB=2, FNMSUB=3, FNMADD=4, FADD=5, FSUB=6, FMUL=7, FDIV=8, FSQRT=9, FSGNJ=10, FSGNJN=11, FSGNJX=12, FMIN=13, FMAX=14, FCVRTWS=15, FCVRTWUS=16, FMVXW=17, FEQ=18, FLT=19, FLE=20, FCLASS=21, FCVRTSW=22, FCVRTSWU=23, FMVWX=24; 25–31 invalid.
- `rd`, `rs1`, `rs2`, `rs3`  in  5 each: register fields.
- `rm`  in  3: rounding mode, placed in bits [14:12] for arithmetic ops.
- `instruction`  out  32: registered word to the FPU.
- `issued`  out  1: high while `instruction` holds a real (non-bubble) word.
- `reject`  out  1: one-cycle pulse after an unsupported op_code is consumed.
- `issue_count`, `bubble_count`  out  `CNT_W`: saturating counters.

## Operation
- **Output register.** `instruction` updates every edge. It loads either the encoded accepted op or the bubble word 32'h0000_0000.
- **Common encoding fields.** [6:0] opcode, [11:7] rd, [19:15] rs1, [24:20] rs2, [26:25] fmt = 2'b00.
- **FMA family.** Opcodes: FMADD 7'b1000011, FMSUB 7'b1000111, FNMSUB 7'b1001011, FNMADD 7'b1001111. [31:27] = rs3; [14:12] = rm.
- **OP-FP family.** Opcode 7'b1010011; [31:27] = funct5.
  - FADD 00000, FSUB 00001, FMUL 00010, FDIV 00011: funct3 = rm.
  - FSQRT 01011: funct3 = rm, rs2 forced to 0.
  - FSGNJ/FSGNJN/FSGNJX 00100: funct3 000/001/010.
  - FMIN/FMAX 00101: funct3 000/001.
  - FLE/FLT/FEQ 10100: funct3 000/001/010.
  - FCLASS 11100: funct3 001, rs2 forced to 0.
- **Sources used.** rs1 by all supported ops. rs2 by all except FSQRT and FCLASS. rs3 by the FMA family only.
- **Unsupported ops.** FNOP, the CVT/MV family, and codes 25–31:
  - accepted with no hazard check;
  - emit a bubble and pulse `reject`;
  - never enter the scoreboard.
- **Scoreboard.** A shift register of `HAZARD_DEPTH` entries {valid, rd}.
  - Every edge, slot0 loads {issued-real, rd}; slots shift toward the oldest; the oldest entry drops out.
  - Bubbles load valid=0.
- **Hazard.** Hazard = `op_valid` AND supported op AND any *used* source equals a valid slot's rd. f0 is an ordinary register.
  - Hazard only; a WAW conflict alone never stalls.
- **Ready.** `op_ready` = !rst AND !hazard. It is combinational from the op fields and the scoreboard.
- **Counters.** `issue_count` increments per real word. `bubble_count` increments per bubble emitted while `op_valid` is high (stall or reject). Both saturate at all-ones.

## Timing
- **Reset (async assert).** `instruction`=0, `issued`=0, `reject`=0, scoreboard cleared, counters 0. `op_ready` is low while `rst` is high. Deassertion takes effect at the next edge.
- **Reset mid-stream.** In-flight scoreboard entries are discarded; the first op after reset issues without stall.
- **Latency.** Op accepted at edge E → word on `instruction` and `issued`=1 from E until E+1.
- **Dependent issue.** A producer accepted at edge E blocks a dependent op until edge E+4, which gives three bubble words between them. Independent ops issue back-to-back, one per cycle.
- **Idle.** `op_valid` low → bubble each cycle; scoreboard ages normally.
- **Simultaneous hazard on multiple slots.** Stall until the youngest matching entry retires.

## Test plan
- **Reset.** Assert `rst` mid-traffic → `instruction`=0 immediately, `op_ready`=0. After release, FADD f1,f2,f3,rm=000 issues as 32'h0031_00D3.
- **Back-to-back independent.** FMUL f4,f5,f6 then FSUB f7,f8,f9 on consecutive cycles → two consecutive real words, no bubbles, `issue_count`=2.
- **RAW stall.** FADD f1,f2,f3 at E, then FDIV f10,f1,f2 → `op_ready` low for 3 cycles, 3 bubbles, FDIV word appears after E+4, `bubble_count`=3.
- **FMA rs3 hazard.** FMUL f9 at E, then FMADD f1,f2,f3,f9 → stalls 3 cycles. The same FMADD after FSQRT f9,f4 also stalls. FSQRT f5,f6 after FMUL f9 does not stall (its rs2 field is ignored).
- **Reject.** op_code=FCVRTWS → accepted in one cycle, bubble emitted, `reject` pulses once, scoreboard unchanged.
- **Encoding sweep.** Every supported op with rd=1, rs1=2, rs2=3, rs3=4, rm=001 → words match the field layout above, including FEQ funct3=010 and FCLASS [24:20]=0.
